tetris_move_sched: RTL and testbench

- Arbitrates every move request for the active piece and sequences the board datapath: player buttons, gravity ticks and opponent garbage insertion.
- Issues one command at a time over a valid/done handshake to the board collision/update unit.
- Runs the lock -> clear -> spawn sequence and flags game over to the game status FSM.
- Active only while the status code equals GAME_ING (3'b110).

---
 rtl/tetris_pkg.sv | 47 ++++
 rtl/tetris_move_sched_if.sv | 12 +
 rtl/tetris_move_sched_grav_timer.sv | 40 ++++
 rtl/tetris_move_sched.sv | 227 ++++++++++++++++++++++
 tb/tb_tetris_move_sched.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/tetris_pkg.sv
// rtl/tetris_pkg.sv - opcodes, status codes and scheduler state encoding shared by the game core
package tetris_pkg;

    localparam logic [2:0] STAT_GAME_ING = 3'b110;

    typedef enum logic [2:0] {
        OP_LEFT    = 3'd0,
        OP_RIGHT   = 3'd1,
        OP_ROT     = 3'd2,
        OP_DOWN    = 3'd3,
        OP_LOCK    = 3'd4,
        OP_CLEAR   = 3'd5,
        OP_SPAWN   = 3'd6,
        OP_GARBAGE = 3'd7
    } op_e;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_HARD,
        S_LOCK,
        S_CLEAR,
        S_SPAWN,
        S_OVER
`ifdef TETRIS_LOCK_DELAY_EN
        , S_LOCKWAIT
`endif
    } state_e;

    // Requester slots, listed in grant priority order (lowest index wins)
    localparam int NREQ = 7;
    localparam logic [2:0] R_GARB  = 3'd0;
    localparam logic [2:0] R_DROP  = 3'd1;
    localparam logic [2:0] R_GRAV  = 3'd2;
    localparam logic [2:0] R_ROT   = 3'd3;
    localparam logic [2:0] R_LEFT  = 3'd4;
    localparam logic [2:0] R_RIGHT = 3'd5;
    localparam logic [2:0] R_DOWN  = 3'd6;

    function automatic logic [2:0] sat_add3(input logic [2:0] a, input logic [2:0] b);
        logic [3:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[3] ? 3'd7 : s[2:0];
    endfunction

endpackage

// File: rtl/tetris_move_sched_if.sv
// rtl/tetris_move_sched_if.sv - command handshake between move scheduler and board datapath
interface tetris_move_sched_if;
    logic       cmd_valid;
    logic [2:0] cmd_op;
    logic [2:0] cmd_arg;
    logic       cmd_done;
    logic       cmd_ok;
    logic [2:0] lines_cleared;

    modport master (output cmd_valid, cmd_op, cmd_arg, input cmd_done, cmd_ok, lines_cleared);
    modport slave  (input cmd_valid, cmd_op, cmd_arg, output cmd_done, cmd_ok, lines_cleared);
endinterface

// File: rtl/tetris_move_sched_grav_timer.sv
// rtl/tetris_move_sched_grav_timer.sv - level-scaled gravity interval counter producing a tick pulse
module grav_timer #(
    parameter int GRAV_W    = 27,
    parameter int GRAV_BASE = 50_000_000,
    parameter int GRAV_STEP = 3_000_000,
    parameter int GRAV_MIN  = 5_000_000
) (
    input  logic       global_clk,
    input  logic       rst,
    input  logic       en,
    input  logic       clr,
    input  logic [3:0] level,
    output logic       tick
);
    localparam int IW = GRAV_W + 4;

    logic [IW-1:0]     prod;
    logic [IW-1:0]     interval;
    logic [GRAV_W-1:0] cnt;

    // Compare before subtracting so high levels cannot underflow the interval
    always_comb begin
        prod = IW'(level) * IW'(GRAV_STEP);
        if (prod + IW'(GRAV_MIN) >= IW'(GRAV_BASE))
            interval = IW'(GRAV_MIN);
        else
            interval = IW'(GRAV_BASE) - prod;
    end

    assign tick = en && ({4'b0, cnt} >= interval - IW'(1));

    always_ff @(posedge global_clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clr || tick)
            cnt <= '0;
        else if (en)
            cnt <= cnt + GRAV_W'(1);
    end
endmodule

// File: rtl/tetris_move_sched.sv
// rtl/tetris_move_sched.sv - move arbiter and lock/clear/spawn sequencer; TETRIS_LOCK_DELAY_EN adds LOCKWAIT
module tetris_move_sched
    import tetris_pkg::*;
#(
    parameter int GRAV_W    = 27,
    parameter int GRAV_BASE = 50_000_000,
    parameter int GRAV_STEP = 3_000_000,
    parameter int GRAV_MIN  = 5_000_000
`ifdef TETRIS_LOCK_DELAY_EN
    , parameter int LOCK_DELAY = 25_000_000
`endif
) (
    input  logic                       global_clk,
    input  logic                       rst,
    input  logic [2:0]                 stat_in,
    input  logic                       btn_left,
    input  logic                       btn_right,
    input  logic                       btn_rotate,
    input  logic                       btn_down,
    input  logic                       btn_drop,
    input  logic                       garbage_req,
    input  logic [2:0]                 garbage_lines,
    input  logic [3:0]                 level,
    tetris_move_sched_if.master        bus,
    output logic [2:0]                 clr_count,
    output logic                       game_over,
    output logic                       busy
);
    state_e          state, state_n;
    logic            ing, grav_tick, spawn_ok, done;
    logic [NREQ-1:0] pend, set_mask, clr_mask;
    logic [2:0]      gcnt, win, op_n, arg_n, clr_n;
    logic            w_grav, grav_n, valid_n, over_n;
`ifdef TETRIS_LOCK_DELAY_EN
    logic            in_lw, in_lw_n;
    logic [31:0]     lw_cnt, lw_cnt_n;
    logic [3:0]      lw_rst, lw_rst_n;
`endif

    assign ing  = (stat_in == STAT_GAME_ING);
    assign done = bus.cmd_valid & bus.cmd_done;
    assign busy = (state != S_IDLE);
    assign set_mask = {NREQ{ing}} & {btn_down, btn_right, btn_left, btn_rotate, grav_tick,
                                     btn_drop & (state != S_HARD), garbage_req};

    grav_timer #(.GRAV_W(GRAV_W), .GRAV_BASE(GRAV_BASE), .GRAV_STEP(GRAV_STEP), .GRAV_MIN(GRAV_MIN)) u_grav (
        .global_clk(global_clk), .rst(rst), .en(ing), .clr(spawn_ok), .level(level), .tick(grav_tick)
    );

    always_comb begin
        win = 3'd0;
        for (int i = NREQ - 1; i >= 0; i--)
            if (pend[i]) win = 3'(i);
    end

    // A set arriving in the grant cycle survives the clear, so the request is not lost
    always_ff @(posedge global_clk or posedge rst) begin
        if (rst || !ing) begin
            pend <= '0;
            gcnt <= '0;
        end else begin
            pend <= (pend & ~clr_mask) | set_mask;
            if (garbage_req)
                gcnt <= sat_add3(clr_mask[R_GARB] ? 3'd0 : gcnt, garbage_lines);
            else if (clr_mask[R_GARB])
                gcnt <= '0;
        end
    end

    always_comb begin
        state_n  = state;
        valid_n  = bus.cmd_valid;
        op_n     = bus.cmd_op;
        arg_n    = bus.cmd_arg;
        grav_n   = w_grav;
        clr_mask = '0;
        over_n   = 1'b0;
        clr_n    = clr_count;
        spawn_ok = 1'b0;
`ifdef TETRIS_LOCK_DELAY_EN
        in_lw_n  = in_lw;
        lw_cnt_n = lw_cnt;
        lw_rst_n = lw_rst;
`endif
        case (state)
            S_IDLE: begin
`ifdef TETRIS_LOCK_DELAY_EN
                in_lw_n = 1'b0;
`endif
                if (ing && |pend) begin
                    clr_mask[win] = 1'b1;
                    grav_n  = (win == R_GRAV);
                    arg_n   = (win == R_GARB) ? gcnt : 3'd0;
                    state_n = (win == R_DROP) ? S_HARD : S_ISSUE;
                    case (win)
                        R_GARB:  op_n = OP_GARBAGE;
                        R_ROT:   op_n = OP_ROT;
                        R_LEFT:  op_n = OP_LEFT;
                        R_RIGHT: op_n = OP_RIGHT;
                        default: op_n = OP_DOWN;
                    endcase
                end
            end
            S_ISSUE: begin
                if (!ing) state_n = S_IDLE;
                else begin
                    valid_n = 1'b1;
                    state_n = S_WAIT;
                end
            end
            S_WAIT: begin
                if (done) begin
                    valid_n = 1'b0;
                    if (!ing) state_n = S_IDLE;
`ifdef TETRIS_LOCK_DELAY_EN
                    else if (in_lw) begin
                        in_lw_n = 1'b0;
                        state_n = S_LOCKWAIT;
                        if (bus.cmd_ok && lw_rst < 4'd8) begin
                            lw_cnt_n = '0;
                            lw_rst_n = lw_rst + 4'd1;
                        end
                    end else if (w_grav && !bus.cmd_ok) begin
                        lw_cnt_n = '0;
                        lw_rst_n = '0;
                        state_n  = S_LOCKWAIT;
                    end
`else
                    else if (w_grav && !bus.cmd_ok) state_n = S_LOCK;
`endif
                    else state_n = S_IDLE;
                end
            end
            S_HARD, S_LOCK, S_CLEAR, S_SPAWN: begin
                if (!bus.cmd_valid) begin
                    if (!ing) state_n = S_IDLE;
                    else begin
                        valid_n = 1'b1;
                        arg_n   = 3'd0;
                        case (state)
                            S_LOCK:  op_n = OP_LOCK;
                            S_CLEAR: op_n = OP_CLEAR;
                            S_SPAWN: op_n = OP_SPAWN;
                            default: op_n = OP_DOWN;
                        endcase
                    end
                end else if (bus.cmd_done) begin
                    valid_n = 1'b0;
                    if (state == S_CLEAR) clr_n = bus.lines_cleared;
                    if (state == S_SPAWN && bus.cmd_ok) spawn_ok = 1'b1;
                    if (!ing) state_n = S_IDLE;
                    else begin
                        case (state)
                            S_HARD:  if (!bus.cmd_ok) state_n = S_LOCK;
                            S_LOCK:  state_n = S_CLEAR;
                            S_CLEAR: state_n = S_SPAWN;
                            default: begin
                                if (bus.cmd_ok) state_n = S_IDLE;
                                else begin
                                    over_n  = 1'b1;
                                    state_n = S_OVER;
                                end
                            end
                        endcase
                    end
                end
            end
            S_OVER: if (!ing) state_n = S_IDLE;
`ifdef TETRIS_LOCK_DELAY_EN
            S_LOCKWAIT: begin
                lw_cnt_n = lw_cnt + 32'd1;
                if (!ing) state_n = S_IDLE;
                else if (pend[R_DROP] || lw_cnt >= 32'(LOCK_DELAY - 1)) begin
                    clr_mask[R_DROP] = pend[R_DROP];
                    state_n = S_LOCK;
                end else if (pend[R_ROT] || pend[R_LEFT] || pend[R_RIGHT]) begin
                    in_lw_n = 1'b1;
                    grav_n  = 1'b0;
                    arg_n   = 3'd0;
                    state_n = S_ISSUE;
                    if (pend[R_ROT]) begin
                        clr_mask[R_ROT] = 1'b1;
                        op_n = OP_ROT;
                    end else if (pend[R_LEFT]) begin
                        clr_mask[R_LEFT] = 1'b1;
                        op_n = OP_LEFT;
                    end else begin
                        clr_mask[R_RIGHT] = 1'b1;
                        op_n = OP_RIGHT;
                    end
                end
            end
`endif
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge global_clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            bus.cmd_valid <= 1'b0;
            bus.cmd_op    <= 3'd0;
            bus.cmd_arg   <= 3'd0;
            w_grav        <= 1'b0;
            game_over     <= 1'b0;
            clr_count     <= 3'd0;
`ifdef TETRIS_LOCK_DELAY_EN
            in_lw         <= 1'b0;
            lw_cnt        <= '0;
            lw_rst        <= '0;
`endif
        end else begin
            state         <= state_n;
            bus.cmd_valid <= valid_n;
            bus.cmd_op    <= op_n;
            bus.cmd_arg   <= arg_n;
            w_grav        <= grav_n;
            game_over     <= over_n;
            clr_count     <= clr_n;
`ifdef TETRIS_LOCK_DELAY_EN
            in_lw         <= in_lw_n;
            lw_cnt        <= lw_cnt_n;
            lw_rst        <= lw_rst_n;
`endif
        end
    end
endmodule

// File: tb/tb_tetris_move_sched.sv
// tb/tb_tetris_move_sched.sv - directed self-checking bench for tetris_move_sched
module tb_tetris_move_sched;
    import tetris_pkg::*;

    logic       global_clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] stat_in = 3'b110;
    logic       btn_left = 0, btn_right = 0, btn_rotate = 0, btn_down = 0, btn_drop = 0;
    logic       garbage_req = 0;
    logic [2:0] garbage_lines = 0;
    logic [3:0] level = 0;
    logic [2:0] clr_count;
    logic       game_over, busy;
    int         cyc = 0;
    int         checks = 0;
    int         failures = 0;

    tetris_move_sched_if bus();

    tetris_move_sched #(.GRAV_W(27), .GRAV_BASE(100), .GRAV_STEP(10), .GRAV_MIN(40)) dut (
        .global_clk(global_clk), .rst(rst), .stat_in(stat_in),
        .btn_left(btn_left), .btn_right(btn_right), .btn_rotate(btn_rotate),
        .btn_down(btn_down), .btn_drop(btn_drop),
        .garbage_req(garbage_req), .garbage_lines(garbage_lines), .level(level),
        .bus(bus), .clr_count(clr_count), .game_over(game_over), .busy(busy)
    );

    always #5 global_clk = ~global_clk;
    always @(posedge global_clk) cyc <= cyc + 1;

    typedef struct {
        logic       l, r, rot, dn, garb;
        logic [2:0] gl;
        logic       ok0;
        int         nops;
        logic [2:0] op0, arg0, op1;
    } vec_t;

    typedef struct {
        logic [3:0] lvl;
        int         interval;
    } grav_t;

    vec_t  vecs[9];
    grav_t gvecs[6];

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge global_clk);
        rst = 1'b1;
        @(negedge global_clk);
        rst = 1'b0;
    endtask

    task automatic wait_cmd(input string name, input int exp_op, input int exp_arg, output int t);
        int n;
        n = 0;
        while (!bus.cmd_valid && n < 200) begin
            @(negedge global_clk);
            n++;
        end
        t = cyc;
        if (!bus.cmd_valid) begin
            checks++;
            failures++;
            $display("FAIL %s: no cmd_valid within 200 cycles", name);
        end else begin
            check($sformatf("%s op", name), int'(bus.cmd_op), exp_op);
            check($sformatf("%s arg", name), int'(bus.cmd_arg), exp_arg);
        end
    endtask

    task automatic finish_cmd(input string name, input logic ok, input logic [2:0] lines, output logic go);
        bus.cmd_ok = ok;
        bus.lines_cleared = lines;
        bus.cmd_done = 1'b1;
        @(negedge global_clk);
        bus.cmd_done = 1'b0;
        bus.cmd_ok = 1'b0;
        go = game_over;
        check($sformatf("%s valid low after done", name), int'(bus.cmd_valid), 0);
    endtask

    task automatic serve(input string name, input int op, input logic ok, input logic [2:0] lines);
        int t;
        logic go;
        wait_cmd(name, op, 0, t);
        finish_cmd(name, ok, lines, go);
    endtask

    task automatic count_valid(input int cycles, output int hits);
        hits = 0;
        repeat (cycles) begin
            @(negedge global_clk);
            if (bus.cmd_valid) hits++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t0, t1, t2, hits;
        logic go;
        bus.cmd_done = 0;
        bus.cmd_ok = 0;
        bus.lines_cleared = 0;

        //            l  r  rot dn garb gl ok nops op0 arg0 op1
        vecs[0] = '{1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0};
        vecs[1] = '{0, 1, 0, 0, 0, 0, 1, 1, 1, 0, 0};
        vecs[2] = '{0, 0, 1, 0, 0, 0, 1, 1, 2, 0, 0};
        vecs[3] = '{0, 0, 0, 1, 0, 0, 0, 1, 3, 0, 0};
        vecs[4] = '{1, 0, 1, 0, 0, 0, 1, 2, 2, 0, 0};
        vecs[5] = '{1, 1, 0, 0, 0, 0, 1, 2, 0, 0, 1};
        vecs[6] = '{0, 0, 0, 1, 1, 3, 1, 2, 7, 3, 3};
        vecs[7] = '{0, 0, 1, 1, 0, 0, 1, 2, 2, 0, 3};
        vecs[8] = '{0, 0, 0, 0, 1, 7, 1, 1, 7, 7, 0};

        gvecs[0] = '{4'd7, 40};
        gvecs[1] = '{4'd2, 80};
        gvecs[2] = '{4'd0, 100};
        gvecs[3] = '{4'd6, 40};
        gvecs[4] = '{4'd5, 50};
        gvecs[5] = '{4'd15, 40};

        do_reset();
        check("reset busy", int'(busy), 0);
        check("reset valid", int'(bus.cmd_valid), 0);
        check("reset game_over", int'(game_over), 0);

        foreach (vecs[k]) begin
            do_reset();
            btn_left = vecs[k].l; btn_right = vecs[k].r; btn_rotate = vecs[k].rot;
            btn_down = vecs[k].dn; garbage_req = vecs[k].garb; garbage_lines = vecs[k].gl;
            @(negedge global_clk);
            btn_left = 0; btn_right = 0; btn_rotate = 0; btn_down = 0; garbage_req = 0; garbage_lines = 0;
            wait_cmd($sformatf("vec%0d cmd0", k), int'(vecs[k].op0), int'(vecs[k].arg0), t0);
            finish_cmd($sformatf("vec%0d cmd0", k), vecs[k].ok0, 3'd0, go);
            if (vecs[k].nops > 1) begin
                wait_cmd($sformatf("vec%0d cmd1", k), int'(vecs[k].op1), 0, t0);
                finish_cmd($sformatf("vec%0d cmd1", k), 1'b1, 3'd0, go);
            end
            repeat (4) @(negedge global_clk);
            check($sformatf("vec%0d idle busy", k), int'(busy), 0);
            check($sformatf("vec%0d idle valid", k), int'(bus.cmd_valid), 0);
        end

        foreach (gvecs[k]) begin
            level = gvecs[k].lvl;
            do_reset();
            wait_cmd($sformatf("grav%0d t0", k), 3, 0, t0);
            finish_cmd($sformatf("grav%0d t0", k), 1'b1, 3'd0, go);
            wait_cmd($sformatf("grav%0d t1", k), 3, 0, t1);
            finish_cmd($sformatf("grav%0d t1", k), 1'b1, 3'd0, go);
            wait_cmd($sformatf("grav%0d t2", k), 3, 0, t2);
            finish_cmd($sformatf("grav%0d t2", k), 1'b1, 3'd0, go);
            check($sformatf("grav%0d interval a", k), t1 - t0, gvecs[k].interval);
            check($sformatf("grav%0d interval b", k), t2 - t1, gvecs[k].interval);
        end
        level = 0;

        // hard drop: three legal steps, a blocked one, then lock/clear/spawn
        do_reset();
        btn_drop = 1; @(negedge global_clk); btn_drop = 0;
        serve("drop down1", 3, 1'b1, 3'd0);
        btn_drop = 1; @(negedge global_clk); btn_drop = 0;
        serve("drop down2", 3, 1'b1, 3'd0);
        serve("drop down3", 3, 1'b1, 3'd0);
        serve("drop down4", 3, 1'b0, 3'd0);
        serve("drop lock", 4, 1'b1, 3'd0);
        serve("drop clear", 5, 1'b1, 3'd2);
        serve("drop spawn", 6, 1'b1, 3'd0);
        check("drop clr_count", int'(clr_count), 2);
        count_valid(6, hits);
        check("drop extra pulse discarded", hits, 0);
        check("drop idle busy", int'(busy), 0);

        @(negedge global_clk);
        rst = 1'b1;
        #1;
        check("reset clr_count", int'(clr_count), 0);
        check("reset cmd_op", int'(bus.cmd_op), 0);
        check("reset cmd_arg", int'(bus.cmd_arg), 0);
        @(negedge global_clk);
        rst = 1'b0;

        // spawn failure -> game over
        btn_drop = 1; @(negedge global_clk); btn_drop = 0;
        serve("go down", 3, 1'b0, 3'd0);
        serve("go lock", 4, 1'b1, 3'd0);
        serve("go clear", 5, 1'b1, 3'd0);
        wait_cmd("go spawn", 6, 0, t0);
        finish_cmd("go spawn", 1'b0, 3'd0, go);
        check("game_over pulse", int'(go), 1);
        @(negedge global_clk);
        check("game_over one cycle", int'(game_over), 0);
        btn_left = 1; @(negedge global_clk); btn_left = 0;
        count_valid(20, hits);
        check("over no commands", hits, 0);
        check("over busy", int'(busy), 1);
        stat_in = 3'b000;
        repeat (2) @(negedge global_clk);
        check("over exit busy", int'(busy), 0);
        stat_in = 3'b110;

        // garbage coalescing with saturation while a move is outstanding
        do_reset();
        btn_left = 1; @(negedge global_clk); btn_left = 0;
        wait_cmd("garb left", 0, 0, t0);
        garbage_req = 1; garbage_lines = 5;
        @(negedge global_clk);
        garbage_lines = 4;
        @(negedge global_clk);
        garbage_req = 0; garbage_lines = 0;
        finish_cmd("garb left", 1'b1, 3'd0, go);
        wait_cmd("garb sat", 7, 7, t0);
        finish_cmd("garb sat", 1'b1, 3'd0, go);
        count_valid(5, hits);
        check("garb single command", hits, 0);

        // status leaves GAME_ING mid-command: finish it, drop pending right
        do_reset();
        btn_left = 1; btn_right = 1; @(negedge global_clk); btn_left = 0; btn_right = 0;
        wait_cmd("stat left", 0, 0, t0);
        stat_in = 3'b000;
        @(negedge global_clk);
        check("stat valid held", int'(bus.cmd_valid), 1);
        finish_cmd("stat left", 1'b1, 3'd0, go);
        repeat (2) @(negedge global_clk);
        check("stat idle busy", int'(busy), 0);
        stat_in = 3'b110;
        count_valid(6, hits);
        check("stat flags cleared", hits, 0);

        // asynchronous reset while WAIT holds cmd_valid
        do_reset();
        btn_left = 1; @(negedge global_clk); btn_left = 0;
        wait_cmd("rst left", 0, 0, t0);
        rst = 1'b1;
        #1;
        check("async reset valid", int'(bus.cmd_valid), 0);
        check("async reset busy", int'(busy), 0);
        @(negedge global_clk);
        rst = 1'b0;
        count_valid(10, hits);
        check("no command after reset", hits, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
